// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, manager FSM states, default prot.
// Imported by the manager and by benches.
package axi4_lite_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } mgr_state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite channel bundle with manager (M) and subordinate (S) views.
// Strobe width follows the data width.
interface axi4_lite_if #(
  parameter int ALEN = 64,
  parameter int DLEN = 64
);
  localparam int SLEN = DLEN / 8;

  logic            awvalid;
  logic            awready;
  logic [ALEN-1:0] awaddr;
  logic [2:0]      awprot;
  logic            wvalid;
  logic            wready;
  logic [DLEN-1:0] wdata;
  logic [SLEN-1:0] wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [ALEN-1:0] araddr;
  logic [2:0]      arprot;
  logic            rvalid;
  logic            rready;
  logic [DLEN-1:0] rdata;
  logic [1:0]      rresp;

  modport M (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport S (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_manager.sv
// Single-outstanding AXI4-Lite initiator behind a valid/ready command port.
// Optional error counter: define AXI4_LITE_MANAGER_ERRCNT_EN.
module axi4_lite_manager
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ALEN = 64,
  parameter int AXI_DLEN = 64,
  parameter int AXI_SLEN = AXI_DLEN / 8
) (
  input  logic                clk,
  input  logic                rstn,
  axi4_lite_if.M              axi,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_write,
  input  logic [AXI_ALEN-1:0] i_req_addr,
  input  logic [AXI_DLEN-1:0] i_req_wdata,
  input  logic [AXI_SLEN-1:0] i_req_wstrb,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic                o_rsp_write,
  output logic [AXI_DLEN-1:0] o_rsp_rdata,
  output logic [1:0]          o_rsp_resp
`ifdef AXI4_LITE_MANAGER_ERRCNT_EN
  ,
  output logic [15:0]         o_err_cnt
`endif
);
  mgr_state_t state;

  logic awvalid;
  logic wvalid;
  logic bready;
  logic arvalid;
  logic rready;
  logic [AXI_ALEN-1:0] addr;
  logic [AXI_DLEN-1:0] wdata;
  logic [AXI_SLEN-1:0] wstrb;

  logic aw_hs;
  logic w_hs;
  logic aw_done;
  logic w_done;
  logic b_cap;
  logic r_cap;

  assign axi.awvalid = awvalid;
  assign axi.awaddr  = addr;
  assign axi.awprot  = PROT_DEFAULT;
  assign axi.wvalid  = wvalid;
  assign axi.wdata   = wdata;
  assign axi.wstrb   = wstrb;
  assign axi.bready  = bready;
  assign axi.arvalid = arvalid;
  assign axi.araddr  = addr;
  assign axi.arprot  = PROT_DEFAULT;
  assign axi.rready  = rready;

  assign aw_hs = awvalid & axi.awready;
  assign w_hs  = wvalid & axi.wready;
  // A valid only ever drops through its own handshake, so low means done.
  assign aw_done = ~awvalid | aw_hs;
  assign w_done  = ~wvalid | w_hs;
  assign b_cap = (state == WR_RESP) & axi.bvalid & bready;
  assign r_cap = (state == RD_DATA) & axi.rvalid & rready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      o_req_ready <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_write <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_resp  <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (o_req_ready && i_req_valid) begin
            o_req_ready <= 1'b0;
            o_rsp_write <= i_req_write;
            addr        <= i_req_addr;
            wdata       <= i_req_wdata;
            wstrb       <= i_req_wstrb;
            if (i_req_write) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_REQ;
            end
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        WR_REQ: begin
          if (aw_hs) awvalid <= 1'b0;
          if (w_hs) wvalid <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_cap) begin
            bready      <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_resp  <= axi.bresp;
            o_rsp_valid <= 1'b1;
            state       <= RSP;
          end
        end
        RD_REQ: begin
          if (axi.arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_cap) begin
            rready      <= 1'b0;
            o_rsp_rdata <= axi.rdata;
            o_rsp_resp  <= axi.rresp;
            o_rsp_valid <= 1'b1;
            state       <= RSP;
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI4_LITE_MANAGER_ERRCNT_EN
  logic [1:0] cap_resp;
  assign cap_resp = b_cap ? axi.bresp : axi.rresp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_err_cnt <= 16'h0000;
    end else if ((b_cap || r_cap) && resp_t'(cap_resp) != OKAY
                 && o_err_cnt != 16'hFFFF) begin
      o_err_cnt <= o_err_cnt + 16'h0001;
    end
  end
`else
  // Without the counter, error responses are visible only on o_rsp_resp.
`endif
endmodule

// File: tb/tb_axi4_lite_manager.sv
// Scoreboard bench for axi4_lite_manager against a one-register GPIO subordinate.
// Define AXI4_LITE_MANAGER_ERRCNT_EN to also check o_err_cnt.
module tb_axi4_lite_manager;
  import axi4_lite_pkg::*;

  typedef struct {
    logic        wr;
    logic [63:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_write;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
`ifdef AXI4_LITE_MANAGER_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  axi4_lite_if #(.ALEN(64), .DLEN(64)) axi ();

  axi4_lite_manager #(
    .AXI_ALEN(64),
    .AXI_DLEN(64),
    .AXI_SLEN(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .axi(axi),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_write(req_write),
    .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .i_req_wstrb(req_wstrb),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_write(rsp_write),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_resp(rsp_resp)
`ifdef AXI4_LITE_MANAGER_ERRCNT_EN
    ,
    .o_err_cnt(err_cnt)
`endif
  );

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // GPIO subordinate: LED register at 0x0, everything else DECERR.
  logic        aw_rdy = 1'b1;
  logic        w_rdy = 1'b1;
  logic        s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [63:0] s_rdata;
  logic        aw_got, w_got;
  logic [63:0] awa, wd;
  logic [7:0]  ws;
  logic [7:0]  led = 8'h00;
  logic        aw_hs, w_hs, ar_hs;
  logic [63:0] c_awa, c_wd;
  logic [7:0]  c_ws;

  assign axi.awready = aw_rdy;
  assign axi.wready  = w_rdy;
  assign axi.arready = 1'b1;
  assign axi.bvalid  = s_bvalid;
  assign axi.bresp   = s_bresp;
  assign axi.rvalid  = s_rvalid;
  assign axi.rdata   = s_rdata;
  assign axi.rresp   = s_rresp;

  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid & axi.wready;
  assign ar_hs = axi.arvalid & axi.arready;
  assign c_awa = aw_hs ? axi.awaddr : awa;
  assign c_wd  = w_hs ? axi.wdata : wd;
  assign c_ws  = w_hs ? axi.wstrb : ws;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_got <= 0; w_got <= 0; s_bvalid <= 0; s_rvalid <= 0;
      s_bresp <= 0; s_rresp <= 0; s_rdata <= 0;
      awa <= 0; wd <= 0; ws <= 0;
    end else begin
      if (aw_hs) awa <= axi.awaddr;
      if (w_hs) begin wd <= axi.wdata; ws <= axi.wstrb; end
      if ((aw_got | aw_hs) && (w_got | w_hs) && !s_bvalid) begin
        s_bvalid <= 1; aw_got <= 0; w_got <= 0;
        if (c_awa == 64'h0) begin
          s_bresp <= 2'b00;
          if (c_ws[0]) led <= c_wd[7:0];
        end else s_bresp <= 2'b11;
      end else begin
        aw_got <= aw_got | aw_hs; w_got <= w_got | w_hs;
      end
      if (s_bvalid && axi.bready) s_bvalid <= 0;
      if (ar_hs) begin
        s_rvalid <= 1;
        if (axi.araddr == 64'h0) begin
          s_rdata <= {56'h0, led}; s_rresp <= 2'b00;
        end else begin
          s_rdata <= 64'h0; s_rresp <= 2'b11;
        end
      end
      if (s_rvalid && axi.rready) s_rvalid <= 0;
    end
  end

  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
  always @(posedge clk) begin
    if (rstn && aw_hs) aw_cnt <= aw_cnt + 1;
    if (rstn && w_hs) w_cnt <= w_cnt + 1;
    if (rstn && s_bvalid && axi.bready) b_cnt <= b_cnt + 1;
    if (rstn && ar_hs) ar_cnt <= ar_cnt + 1;
  end

  // Handshake rules: valid/payload held until accepted, response held until taken.
  int viol = 0;
  logic p_aw = 0, p_w = 0, p_ar = 0, p_rsp = 0;
  logic [63:0] p_awa, p_wd, p_ara, p_rd;
  logic [1:0]  p_rr;
  always @(posedge clk) begin
    if (rstn) begin
      if (p_aw && !(axi.awvalid && axi.awaddr == p_awa)) viol <= viol + 1;
      if (p_w && !(axi.wvalid && axi.wdata == p_wd)) viol <= viol + 1;
      if (p_ar && !(axi.arvalid && axi.araddr == p_ara)) viol <= viol + 1;
      if (p_rsp && !(rsp_valid && rsp_rdata == p_rd && rsp_resp == p_rr))
        viol <= viol + 1;
      if (axi.awprot != 3'b000 || axi.arprot != 3'b000) viol <= viol + 1;
    end
    p_aw  <= rstn && axi.awvalid && !axi.awready;
    p_w   <= rstn && axi.wvalid && !axi.wready;
    p_ar  <= rstn && axi.arvalid && !axi.arready;
    p_rsp <= rstn && rsp_valid && !rsp_ready;
    p_awa <= axi.awaddr; p_wd <= axi.wdata; p_ara <= axi.araddr;
    p_rd  <= rsp_rdata; p_rr <= rsp_resp;
  end

  always @(negedge clk) begin
    if (rstn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected got=%0h want=none", rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_write", {63'h0, rsp_write}, {63'h0, mon_e.wr});
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_resp", {62'h0, rsp_resp}, {62'h0, mon_e.resp});
      end
    end
  end

  task automatic send_req(input logic wr, input logic [63:0] a,
                          input logic [63:0] d, input logic [7:0] s);
    bit ok = 0;
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    chk("req_accept", {63'h0, ok}, 64'h1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_rsp();
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !rsp_valid) begin ok = 1; break; end
    end
    chk("rsp_done", {63'h0, ok}, 64'h1);
  endtask

  task automatic txn(input logic wr, input logic [63:0] a, input logic [63:0] d,
                     input logic [7:0] s, input logic [63:0] er,
                     input logic [1:0] ersp);
    exp_q.push_back('{wr: wr, rdata: er, resp: ersp});
    send_req(wr, a, d, s);
    wait_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    #23;
    chk("rst_req_ready", {63'h0, req_ready}, 64'h0);
    chk("rst_valids", {59'h0, axi.awvalid, axi.wvalid, axi.arvalid,
        axi.bready, axi.rready}, 64'h0);
    chk("rst_rsp", {63'h0, rsp_valid}, 64'h0);
    chk("rst_rdata", rsp_rdata, 64'h0);
    @(posedge clk); #1; rstn = 1;
    repeat (2) @(posedge clk); #1;
    chk("idle_ready", {63'h0, req_ready}, 64'h1);

    txn(1, 64'h0, 64'hA5, 8'h01, 64'h0, 2'b00);
    chk("led_a5", {56'h0, led}, 64'hA5);
    chk("aw_cnt1", aw_cnt, 1);
    chk("b_cnt1", b_cnt, 1);
    txn(0, 64'h0, 64'h0, 8'h00, 64'hA5, 2'b00);
    chk("ar_cnt1", ar_cnt, 1);

    // AW accepted four cycles after W
    aw_rdy = 0;
    exp_q.push_back('{wr: 1'b1, rdata: 64'h0, resp: 2'b00});
    send_req(1, 64'h0, 64'h3C, 8'h01);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (w_cnt == 2) begin seen = 1; break; end
    end
    chk("w_hs_seen", {63'h0, seen}, 64'h1);
    chk("wvalid_drop", {63'h0, axi.wvalid}, 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("awvalid_hold", {63'h0, axi.awvalid}, 64'h1);
    end
    @(posedge clk); #1; aw_rdy = 1;
    wait_rsp();
    chk("led_3c", {56'h0, led}, 64'h3C);
    chk("aw_cnt2", aw_cnt, 2);
    chk("b_cnt2", b_cnt, 2);

    txn(1, 64'h100, 64'hFF, 8'h01, 64'h0, 2'b11);
    chk("led_keep", {56'h0, led}, 64'h3C);
`ifdef AXI4_LITE_MANAGER_ERRCNT_EN
    chk("err_cnt1", {48'h0, err_cnt}, 64'h1);
`endif

    // Consumer stalls the response for ten cycles
    rsp_ready = 0;
    exp_q.push_back('{wr: 1'b0, rdata: 64'h3C, resp: 2'b00});
    send_req(0, 64'h0, 64'h0, 8'h00);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    chk("stall_valid", {63'h0, seen}, 64'h1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_hold", {62'h0, rsp_valid, req_ready}, 64'h2);
      chk("stall_data", rsp_rdata, 64'h3C);
    end
    chk("stall_ar", ar_cnt, 2);
    chk("stall_aw", aw_cnt, 3);
    @(posedge clk); #1; rsp_ready = 1;
    wait_rsp();

    txn(0, 64'h100, 64'h0, 8'h00, 64'h0, 2'b11);
`ifdef AXI4_LITE_MANAGER_ERRCNT_EN
    chk("err_cnt2", {48'h0, err_cnt}, 64'h2);
`endif

    // Reset while a write is stuck waiting for AW/W
    aw_rdy = 0; w_rdy = 0;
    send_req(1, 64'h0, 64'h77, 8'h01);
    @(negedge clk);
    chk("mid_awvalid", {62'h0, axi.awvalid, axi.wvalid}, 64'h3);
    #2 rstn = 0;
    #1;
    chk("mid_rst_valids", {62'h0, axi.awvalid, axi.wvalid}, 64'h0);
    chk("mid_rst_ready", {63'h0, req_ready}, 64'h0);
    repeat (2) @(posedge clk); #1;
    rstn = 1; aw_rdy = 1; w_rdy = 1;
    repeat (3) @(posedge clk); #1;
    chk("post_rst_ready", {63'h0, req_ready}, 64'h1);
    chk("post_rst_aw", {62'h0, axi.awvalid, rsp_valid}, 64'h0);
    chk("post_rst_b", b_cnt, 3);
`ifdef AXI4_LITE_MANAGER_ERRCNT_EN
    chk("post_rst_err", {48'h0, err_cnt}, 64'h0);
`endif

    // Zero strobe must leave the register untouched
    txn(1, 64'h0, 64'h1234, 8'h00, 64'h0, 2'b00);
    txn(0, 64'h0, 64'h0, 8'h00, 64'h3C, 2'b00);
    chk("b_cnt4", b_cnt, 4);

    repeat (2) @(posedge clk); #1;
    chk("protocol", viol, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
